// File: rtl/ysyx_23060072_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter: FSM state encoding and owner codes.
package ysyx_23060072_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    localparam logic OwnerIfu = 1'b0;
    localparam logic OwnerLsu = 1'b1;

endpackage

// File: rtl/ysyx_23060072_mem_arb_pick.sv
// Arbitration between IFU and LSU with LSU priority and a starvation guard that bounds IFU wait.
module ysyx_23060072_mem_arb_pick #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic idle,
    input  logic handshake_fire,
    output logic grant_ifu,
    output logic grant_lsu
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] starve_q, starve_d;
    logic            starved;

    assign starved = (starve_q == CntW'(STARVE_LIMIT));

    // LSU wins ties unless the IFU has already lost STARVE_LIMIT arbitrations in a row.
    assign grant_lsu = idle && lsu_valid && !(ifu_valid && starved);
    assign grant_ifu = idle && ifu_valid && (!lsu_valid || starved);

    always_comb begin
        starve_d = starve_q;
        if (handshake_fire && grant_ifu) begin
            starve_d = '0;
        end else if (handshake_fire && grant_lsu && ifu_valid && !starved) begin
            starve_d = starve_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/ysyx_23060072_mem_arbiter.sv
// Shares one memory port between IFU and LSU: one outstanding transaction, response routed to
// whichever requester owned the request.
module ysyx_23060072_mem_arbiter
    import ysyx_23060072_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ifu_req_valid_i,
    output logic        ifu_req_ready_o,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_rsp_valid_o,
    output logic [31:0] ifu_rdata_o,

    input  logic        lsu_req_valid_i,
    output logic        lsu_req_ready_o,
    input  logic        lsu_we_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [3:0]  lsu_wmask_i,
    output logic        lsu_rsp_valid_o,
    output logic [31:0] lsu_rdata_o,

    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        busy_o
);

    arb_state_e  state_q, state_d;
    logic        owner_q;
    logic        mem_req_valid_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wmask_q;

    logic idle, grant_ifu, grant_lsu, ifu_fire, lsu_fire, fire, rsp_fire;

    // Gating with rst_n keeps both ready outputs low while reset is held.
    assign idle = (state_q == StIdle) && rst_n;

    ysyx_23060072_mem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_valid     (ifu_req_valid_i),
        .lsu_valid     (lsu_req_valid_i),
        .idle          (idle),
        .handshake_fire(fire),
        .grant_ifu     (grant_ifu),
        .grant_lsu     (grant_lsu)
    );

    assign ifu_req_ready_o = grant_ifu;
    assign lsu_req_ready_o = grant_lsu;
    assign ifu_fire        = ifu_req_valid_i && grant_ifu;
    assign lsu_fire        = lsu_req_valid_i && grant_lsu;
    assign fire            = ifu_fire || lsu_fire;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (fire)            state_d = StReq;
            StReq:   if (mem_req_ready_i) state_d = StResp;
            StResp:  if (mem_rsp_valid_i) state_d = StIdle;
            default:                      state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            owner_q         <= OwnerIfu;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                mem_req_valid_q <= 1'b1;
                owner_q         <= lsu_fire ? OwnerLsu : OwnerIfu;
                mem_we_q        <= lsu_fire ? lsu_we_i : 1'b0;
                mem_addr_q      <= lsu_fire ? lsu_addr_i : ifu_addr_i;
                mem_wdata_q     <= lsu_fire ? lsu_wdata_i : 32'h0;
                mem_wmask_q     <= lsu_fire ? lsu_wmask_i : 4'b0000;
            end else if (state_q == StReq && mem_req_ready_i) begin
                mem_req_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_fire        = (state_q == StResp) && mem_rsp_valid_i && rst_n;
    assign ifu_rsp_valid_o = rsp_fire && (owner_q == OwnerIfu);
    assign lsu_rsp_valid_o = rsp_fire && (owner_q == OwnerLsu);
    assign ifu_rdata_o     = mem_rdata_i;
    assign lsu_rdata_o     = mem_rdata_i;

    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_we_o        = mem_we_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign mem_wmask_o     = mem_wmask_q;
    assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_ysyx_23060072_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter with immediate-assertion checks.
module tb_ysyx_23060072_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid_i, ifu_req_ready_o, ifu_rsp_valid_o;
    logic [31:0] ifu_addr_i, ifu_rdata_o;
    logic        lsu_req_valid_i, lsu_req_ready_o, lsu_we_i, lsu_rsp_valid_o;
    logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
    logic [3:0]  lsu_wmask_i;
    logic        mem_req_valid_o, mem_req_ready_i, mem_we_o, mem_rsp_valid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_wmask_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_23060072_mem_arbiter #(
        .STARVE_LIMIT(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_req_valid_i(ifu_req_valid_i),
        .ifu_req_ready_o(ifu_req_ready_o),
        .ifu_addr_i     (ifu_addr_i),
        .ifu_rsp_valid_o(ifu_rsp_valid_o),
        .ifu_rdata_o    (ifu_rdata_o),
        .lsu_req_valid_i(lsu_req_valid_i),
        .lsu_req_ready_o(lsu_req_ready_o),
        .lsu_we_i       (lsu_we_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_wmask_i    (lsu_wmask_i),
        .lsu_rsp_valid_o(lsu_rsp_valid_o),
        .lsu_rdata_o    (lsu_rdata_o),
        .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_wmask_o    (mem_wmask_o),
        .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rdata_i    (mem_rdata_i),
        .busy_o         (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs REQ and RESP with no stalls; called right after the handshake edge.
    task automatic finish_txn(input logic owner_lsu, input logic [31:0] rdata);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i     = rdata;
        #1;
        chk("txn_ifu_rsp", {31'h0, ifu_rsp_valid_o}, {31'h0, ~owner_lsu});
        chk("txn_lsu_rsp", {31'h0, lsu_rsp_valid_o}, {31'h0, owner_lsu});
        tick();
        mem_rsp_valid_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h0;
        lsu_req_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h0;
        lsu_wdata_i = 32'h0; lsu_wmask_i = 4'h0;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rdata_i = 32'h0;
        #2;
        chk("rst_busy", {31'h0, busy_o}, 32'h0);
        chk("rst_mem_valid", {31'h0, mem_req_valid_o}, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_ifu_ready", {31'h0, ifu_req_ready_o}, 32'h0);
        chk("rst_lsu_ready", {31'h0, lsu_req_ready_o}, 32'h0);
        ifu_req_valid_i = 1'b0; lsu_req_valid_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // IFU alone
        ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0000;
        #1;
        chk("ifu_ready", {31'h0, ifu_req_ready_o}, 32'h1);
        chk("ifu_alone_lsu_ready", {31'h0, lsu_req_ready_o}, 32'h0);
        tick();
        ifu_req_valid_i = 1'b0;
        chk("ifu_mem_valid", {31'h0, mem_req_valid_o}, 32'h1);
        chk("ifu_mem_addr", mem_addr_o, 32'h8000_0000);
        chk("ifu_mem_we", {31'h0, mem_we_o}, 32'h0);
        chk("ifu_busy", {31'h0, busy_o}, 32'h1);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h0000_0413;
        #1;
        chk("ifu_rsp_valid", {31'h0, ifu_rsp_valid_o}, 32'h1);
        chk("ifu_rdata", ifu_rdata_o, 32'h0000_0413);
        chk("ifu_lsu_rsp", {31'h0, lsu_rsp_valid_o}, 32'h0);
        tick();
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("ifu_rsp_pulse_end", {31'h0, ifu_rsp_valid_o}, 32'h0);
        chk("ifu_idle", {31'h0, busy_o}, 32'h0);

        // Simultaneous requests: LSU first, IFU next
        ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0004;
        lsu_req_valid_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h8000_0100;
        lsu_wdata_i = 32'h1234_5678; lsu_wmask_i = 4'b0011;
        #1;
        chk("sim_lsu_ready", {31'h0, lsu_req_ready_o}, 32'h1);
        chk("sim_ifu_ready", {31'h0, ifu_req_ready_o}, 32'h0);
        tick();
        lsu_req_valid_i = 1'b0;
        chk("sim_mem_we", {31'h0, mem_we_o}, 32'h1);
        chk("sim_mem_addr", mem_addr_o, 32'h8000_0100);
        chk("sim_mem_wdata", mem_wdata_o, 32'h1234_5678);
        chk("sim_mem_wmask", {28'h0, mem_wmask_o}, 32'h3);
        finish_txn(1'b1, 32'hdead_beef);
        #1;
        chk("sim_ifu_next", {31'h0, ifu_req_ready_o}, 32'h1);
        tick();
        ifu_req_valid_i = 1'b0;
        chk("sim_ifu_addr", mem_addr_o, 32'h8000_0004);
        chk("sim_ifu_we", {31'h0, mem_we_o}, 32'h0);
        chk("sim_ifu_wmask", {28'h0, mem_wmask_o}, 32'h0);
        chk("sim_ifu_wdata", mem_wdata_o, 32'h0);
        finish_txn(1'b0, 32'h0000_0013);

        // Starvation guard: L L L L I L L L L I
        ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0008;
        lsu_req_valid_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h8000_0200;
        for (int i = 0; i < 10; i++) begin
            logic exp_ifu;
            exp_ifu = (i == 4) || (i == 9);
            #1;
            chk($sformatf("starve_ifu_ready_%0d", i), {31'h0, ifu_req_ready_o}, {31'h0, exp_ifu});
            chk($sformatf("starve_lsu_ready_%0d", i), {31'h0, lsu_req_ready_o}, {31'h0, ~exp_ifu});
            tick();
            chk($sformatf("starve_mem_we_%0d", i), {31'h0, mem_we_o}, {31'h0, ~exp_ifu});
            finish_txn(~exp_ifu, 32'h0);
        end
        ifu_req_valid_i = 1'b0; lsu_req_valid_i = 1'b0;

        // Backpressure
        lsu_req_valid_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h8000_0300;
        lsu_wdata_i = 32'haabb_ccdd; lsu_wmask_i = 4'hf;
        tick();
        lsu_req_valid_i = 1'b1; ifu_req_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_req_valid", {31'h0, mem_req_valid_o}, 32'h1);
            chk("bp_req_addr", mem_addr_o, 32'h8000_0300);
            chk("bp_req_wdata", mem_wdata_o, 32'haabb_ccdd);
            chk("bp_req_busy", {31'h0, busy_o}, 32'h1);
            chk("bp_req_rdy", {30'h0, ifu_req_ready_o, lsu_req_ready_o}, 32'h0);
            tick();
        end
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rsp_wait", {30'h0, ifu_rsp_valid_o, lsu_rsp_valid_o}, 32'h0);
            chk("bp_rsp_busy", {31'h0, busy_o}, 32'h1);
            chk("bp_rsp_rdy", {30'h0, ifu_req_ready_o, lsu_req_ready_o}, 32'h0);
            chk("bp_rsp_wmask", {28'h0, mem_wmask_o}, 32'hf);
            tick();
        end
        mem_rsp_valid_i = 1'b1;
        #1;
        chk("bp_rsp_pulse", {30'h0, ifu_rsp_valid_o, lsu_rsp_valid_o}, 32'h1);
        ifu_req_valid_i = 1'b0; lsu_req_valid_i = 1'b0;
        tick();
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("bp_rsp_once", {30'h0, ifu_rsp_valid_o, lsu_rsp_valid_o}, 32'h0);
        chk("bp_idle", {31'h0, busy_o}, 32'h0);

        // Stray responses in IDLE and REQ
        mem_rsp_valid_i = 1'b1;
        #1;
        chk("stray_idle_rsp", {30'h0, ifu_rsp_valid_o, lsu_rsp_valid_o}, 32'h0);
        tick();
        chk("stray_idle_busy", {31'h0, busy_o}, 32'h0);
        ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0010;
        tick();
        ifu_req_valid_i = 1'b0;
        #1;
        chk("stray_req_rsp", {30'h0, ifu_rsp_valid_o, lsu_rsp_valid_o}, 32'h0);
        tick();
        chk("stray_req_hold", {31'h0, mem_req_valid_o}, 32'h1);
        chk("stray_req_busy", {31'h0, busy_o}, 32'h1);
        mem_rsp_valid_i = 1'b0;
        finish_txn(1'b0, 32'h0);

        // Reset while in RESP
        lsu_req_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h8000_0400;
        tick();
        lsu_req_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        chk("rr_in_resp", {31'h0, busy_o}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr_mem_valid", {31'h0, mem_req_valid_o}, 32'h0);
        chk("rr_busy", {31'h0, busy_o}, 32'h0);
        chk("rr_mem_addr", mem_addr_o, 32'h0);
        tick();
        rst_n = 1'b1;
        mem_rsp_valid_i = 1'b1;
        #1;
        chk("rr_late_rsp", {30'h0, ifu_rsp_valid_o, lsu_rsp_valid_o}, 32'h0);
        tick();
        mem_rsp_valid_i = 1'b0;
        chk("rr_still_idle", {31'h0, busy_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
